// File: rtl/pc104_sync_host.sv
// PC104 host-side bus master that services the clock core's sync interrupt:
// on each irq11 rising edge it reads sec/min/hr, then writes a snapshotted
// reference time and a commit word back to the core.
module pc104_sync_host #(
  parameter logic [9:0]  BASE          = 10'h300,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter logic [7:0]  COMMIT_WORD   = 8'h01
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       irq11,
  input  logic [4:0] ref_hr,
  input  logic [5:0] ref_min,
  input  logic [5:0] ref_sec,
  output logic       write_n,
  output logic       read_n,
  output logic [9:0] address,
  output logic       aen,
  output logic [7:0] data_bus_out,
  output logic       data_oe,
  input  logic [7:0] data_bus_in,
  output logic [4:0] cur_hr,
  output logic [5:0] cur_min,
  output logic [5:0] cur_sec,
  output logic       busy,
  output logic       done,
  output logic       range_err
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, FINISH} state_t;

  localparam logic [3:0] LAST_STROBE = 4'(STROBE_CYCLES - 1);

  state_t     state;
  logic [1:0] rst_sync;
  logic       rst_n;
  logic       irq_s1, irq_s2, irq_d, trig;
  logic       pending;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       acc_wr;
  logic [4:0] snap_hr;
  logic [5:0] snap_min, snap_sec;

  logic [2:0] nidx;
  logic [1:0] n_off;
  logic       n_wr;
  logic [7:0] n_data;

  assign rst_n = rst_sync[1];

  // Reset asserts asynchronously, releases two clocks later on a clean edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  // irq11 synchronizer followed by a registered rising-edge detect.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
      irq_d  <= 1'b0;
      trig   <= 1'b0;
    end else begin
      irq_s1 <= irq11;
      irq_s2 <= irq_s1;
      irq_d  <= irq_s2;
      trig   <= irq_s2 & ~irq_d;
    end
  end

  // Decode the access that the next SETUP will present (index 0 from idle,
  // idx+1 from HOLD): reads of offsets 0..2, writes of 0..2, then commit.
  always_comb begin
    nidx   = (state == HOLD) ? idx + 3'd1 : 3'd0;
    n_wr   = (nidx >= 3'd3);
    n_off  = 2'd0;
    n_data = '0;
    if (nidx < 3'd3)       n_off = nidx[1:0];
    else if (nidx == 3'd6) n_off = 2'd3;
    else                   n_off = 2'(nidx - 3'd3);
    case (nidx)
      3'd3:    n_data = {2'b00, snap_sec};
      3'd4:    n_data = {2'b00, snap_min};
      3'd5:    n_data = {3'b000, snap_hr};
      3'd6:    n_data = COMMIT_WORD;
      default: n_data = '0;
    endcase
  end

  // Access sequencer; all bus outputs are registered for the state entered.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      acc_wr       <= 1'b0;
      pending      <= 1'b0;
      snap_hr      <= '0;
      snap_min     <= '0;
      snap_sec     <= '0;
      write_n      <= 1'b1;
      read_n       <= 1'b1;
      aen          <= 1'b1;
      address      <= '0;
      data_bus_out <= '0;
      data_oe      <= 1'b0;
      cur_hr       <= '0;
      cur_min      <= '0;
      cur_sec      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (trig && busy) pending <= 1'b1;
      case (state)
        IDLE, FINISH: begin
          if (trig || pending) begin
            snap_hr      <= ref_hr;
            snap_min     <= ref_min;
            snap_sec     <= ref_sec;
            pending      <= 1'b0;
            idx          <= '0;
            state        <= SETUP;
            busy         <= 1'b1;
            aen          <= 1'b0;
            address      <= BASE + {8'b0, n_off};
            acc_wr       <= n_wr;
            data_bus_out <= n_wr ? n_data : '0;
            data_oe      <= n_wr;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          state   <= STROBE;
          cnt     <= '0;
          read_n  <= acc_wr;
          write_n <= ~acc_wr;
        end
        STROBE: begin
          if (cnt == LAST_STROBE) begin
            state   <= HOLD;
            read_n  <= 1'b1;
            write_n <= 1'b1;
            if (!acc_wr) begin
              case (idx)
                3'd0: begin
                  cur_sec <= data_bus_in[5:0];
                  if (data_bus_in[7:6] != 2'b00 || data_bus_in[5:0] > 6'd59) range_err <= 1'b1;
                end
                3'd1: begin
                  cur_min <= data_bus_in[5:0];
                  if (data_bus_in[7:6] != 2'b00 || data_bus_in[5:0] > 6'd59) range_err <= 1'b1;
                end
                default: begin
                  cur_hr <= data_bus_in[4:0];
                  if (data_bus_in[7:5] != 3'b000 || data_bus_in[4:0] > 5'd23) range_err <= 1'b1;
                end
              endcase
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (idx == 3'd6) begin
            state        <= FINISH;
            done         <= 1'b1;
            busy         <= 1'b0;
            aen          <= 1'b1;
            address      <= '0;
            data_oe      <= 1'b0;
            data_bus_out <= '0;
          end else begin
            idx          <= nidx;
            state        <= SETUP;
            address      <= BASE + {8'b0, n_off};
            acc_wr       <= n_wr;
            data_bus_out <= n_wr ? n_data : '0;
            data_oe      <= n_wr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc104_sync_host.sv
// Self-checking bench for pc104_sync_host: a bus monitor records every access,
// and a rule-level model predicts the trace, captured time, range error and
// done timing for each sync sequence.
module tb_pc104_sync_host;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       irq0, irq1;
  logic [4:0] ref_hr;
  logic [5:0] ref_min, ref_sec;
  logic [7:0] core_val [0:3];

  logic       w0, r0, aen0, oe0, busy0, done0, rerr0;
  logic [9:0] a0;
  logic [7:0] dout0, din0;
  logic [4:0] ch0;
  logic [5:0] cm0, cs0;
  logic       w1, r1, aen1, oe1, busy1, done1, rerr1;
  logic [9:0] a1;
  logic [7:0] dout1, din1;
  logic [4:0] ch1;
  logic [5:0] cm1, cs1;

  assign din0 = core_val[a0[1:0]];
  assign din1 = core_val[a1[1:0]];

  pc104_sync_host dut (
    .clock(clock), .reset_n(reset_n), .irq11(irq0),
    .ref_hr(ref_hr), .ref_min(ref_min), .ref_sec(ref_sec),
    .write_n(w0), .read_n(r0), .address(a0), .aen(aen0),
    .data_bus_out(dout0), .data_oe(oe0), .data_bus_in(din0),
    .cur_hr(ch0), .cur_min(cm0), .cur_sec(cs0),
    .busy(busy0), .done(done0), .range_err(rerr0)
  );

  pc104_sync_host #(.STROBE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .irq11(irq1),
    .ref_hr(ref_hr), .ref_min(ref_min), .ref_sec(ref_sec),
    .write_n(w1), .read_n(r1), .address(a1), .aen(aen1),
    .data_bus_out(dout1), .data_oe(oe1), .data_bus_in(din1),
    .cur_hr(ch1), .cur_min(cm1), .cur_sec(cs1),
    .busy(busy1), .done(done1), .range_err(rerr1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_err = 1'b0;

  always @(posedge clock) cyc++;

  // Bus monitors: access trace, strobe widths, done times, protocol violations.
  logic [18:0] trace0 [$];
  int          width0 [$], done_cyc0 [$], width1 [$], done_cyc1 [$];
  int          viol0 = 0, viol1 = 0, len0 = 0, len1 = 0;
  logic        prev_r0 = 1'b1, prev_w0 = 1'b1;

  always @(negedge clock) begin
    if ((!r0 && !w0) || ((!r0 || !w0) && aen0) || (!w0 && !oe0)) viol0++;
    if (!r0 && prev_r0) trace0.push_back({1'b0, a0, 8'h00});
    if (!w0 && prev_w0) trace0.push_back({1'b1, a0, dout0});
    if (!r0 || !w0) len0++;
    else if (len0 > 0) begin width0.push_back(len0); len0 = 0; end
    if (done0) done_cyc0.push_back(cyc);
    prev_r0 = r0;
    prev_w0 = w0;
  end

  always @(negedge clock) begin
    if ((!r1 && !w1) || ((!r1 || !w1) && aen1) || (!w1 && !oe1)) viol1++;
    if (!r1 || !w1) len1++;
    else if (len1 > 0) begin width1.push_back(len1); len1 = 0; end
    if (done1) done_cyc1.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] enc(input logic wr, input logic [1:0] off, input logic [7:0] d);
    logic [9:0] a;
    a = 10'h300 + {8'h00, off};
    return {wr, a, d};
  endfunction

  task automatic fire0(output int t0);
    @(posedge clock);
    #1 irq0 = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_trace(input int n);
    int k = 0;
    while (trace0.size() < n && k < 300) begin @(negedge clock); k++; end
    check("wait_trace", 32'(trace0.size() >= n), 32'd1);
  endtask

  task automatic wait_done0(input int n);
    int k = 0;
    while (done_cyc0.size() < n && k < 400) begin @(negedge clock); k++; end
    check("wait_done", 32'(done_cyc0.size()), 32'(n));
  endtask

  // Model: expected 7-access trace, captured time, sticky range error.
  task automatic verify0(input string tag, input logic [4:0] rh, input logic [5:0] rm,
                         input logic [5:0] rs, input logic [7:0] vs, input logic [7:0] vm,
                         input logic [7:0] vh);
    logic [18:0] exp [7];
    exp = '{enc(1'b0, 2'd0, 8'h00), enc(1'b0, 2'd1, 8'h00), enc(1'b0, 2'd2, 8'h00),
            enc(1'b1, 2'd0, {2'b00, rs}), enc(1'b1, 2'd1, {2'b00, rm}),
            enc(1'b1, 2'd2, {3'b000, rh}), enc(1'b1, 2'd3, 8'h01)};
    check({tag, "_trace_len"}, 32'(trace0.size() >= 7), 32'd1);
    for (int i = 0; i < 7; i++) begin
      if (trace0.size() > 0) check($sformatf("%s_acc%0d", tag, i), 32'(trace0.pop_front()), 32'(exp[i]));
      if (width0.size() > 0) check($sformatf("%s_width%0d", tag, i), 32'(width0.pop_front()), 32'd4);
    end
    if (vs > 8'd59 || vm > 8'd59 || vh > 8'd23) exp_err = 1'b1;
    check({tag, "_cur_sec"}, 32'(cs0), 32'(vs % 64));
    check({tag, "_cur_min"}, 32'(cm0), 32'(vm % 64));
    check({tag, "_cur_hr"}, 32'(ch0), 32'(vh % 32));
    check({tag, "_range_err"}, 32'(rerr0), 32'(exp_err));
    check({tag, "_viol"}, 32'(viol0), 32'd0);
  endtask

  initial begin
    int t0, d1;
    logic [4:0] oh;
    logic [5:0] om, os;

    reset_n = 1'b0; irq0 = 1'b0; irq1 = 1'b0;
    ref_hr = 5'd5; ref_min = 6'd6; ref_sec = 6'd7;
    core_val[0] = 8'h2A; core_val[1] = 8'h0F; core_val[2] = 8'h11; core_val[3] = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_write_n", 32'(w0), 32'd1);
    check("rst_read_n", 32'(r0), 32'd1);
    check("rst_aen", 32'(aen0), 32'd1);
    check("rst_addr", 32'(a0), 32'd0);
    check("rst_dout_oe", 32'({dout0, oe0}), 32'd0);
    check("rst_cur_busy_done", 32'({ch0, cm0, cs0, busy0, done0, rerr0}), 32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (4) @(posedge clock);

    // Directed: default sequence, timing, ref_sec change before W300 ignored.
    fire0(t0);
    wait_trace(1);
    ref_sec = 6'd33;
    wait_done0(1);
    if (done_cyc0.size() > 0) check("t1_done_time", 32'(done_cyc0.pop_front() - t0), 32'd46);
    verify0("t1", 5'd5, 6'd6, 6'd7, 8'h2A, 8'h0F, 8'h11);
    irq0 = 1'b0;
    repeat (3) @(posedge clock);

    // STROBE_CYCLES=1 instance: 3-clock accesses, 1-clock strobes.
    @(posedge clock);
    #1 irq1 = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 100 && done_cyc1.size() == 0; k++) @(negedge clock);
    check("s1_done_seen", 32'(done_cyc1.size()), 32'd1);
    if (done_cyc1.size() > 0) check("s1_done_time", 32'(done_cyc1.pop_front() - t0), 32'd25);
    check("s1_width_count", 32'(width1.size()), 32'd7);
    while (width1.size() > 0) check("s1_width", 32'(width1.pop_front()), 32'd1);
    check("s1_viol", 32'(viol1), 32'd0);
    irq1 = 1'b0;

    // Randomized sequences with a mid-sequence ref change.
    for (int n = 0; n < 6; n++) begin
      oh = 5'($urandom_range(0, 23)); om = 6'($urandom_range(0, 59)); os = 6'($urandom_range(0, 59));
      ref_hr = oh; ref_min = om; ref_sec = os;
      core_val[0] = 8'($urandom_range(0, 59));
      core_val[1] = 8'($urandom_range(0, 59));
      core_val[2] = 8'($urandom_range(0, 23));
      fire0(t0);
      wait_trace(2);
      ref_hr = 5'($urandom_range(0, 23)); ref_min = 6'($urandom_range(0, 59)); ref_sec = 6'($urandom_range(0, 59));
      wait_done0(1);
      if (done_cyc0.size() > 0) check("rnd_done_time", 32'(done_cyc0.pop_front() - t0), 32'd46);
      verify0($sformatf("rnd%0d", n), oh, om, os, core_val[0], core_val[1], core_val[2]);
      irq0 = 1'b0;
      repeat (3) @(posedge clock);
    end

    // Pending: edges during access 4 and 6 yield exactly two sequences.
    oh = 5'd12; om = 6'd34; os = 6'd56;
    ref_hr = oh; ref_min = om; ref_sec = os;
    core_val[0] = 8'd1; core_val[1] = 8'd2; core_val[2] = 8'd3;
    fire0(t0);
    wait_trace(4);
    irq0 = 1'b0; repeat (3) @(posedge clock); #1 irq0 = 1'b1;
    wait_trace(6);
    irq0 = 1'b0; repeat (3) @(posedge clock); #1 irq0 = 1'b1;
    wait_trace(7);
    ref_hr = 5'd23; ref_min = 6'd59; ref_sec = 6'd1;
    wait_done0(2);
    if (done_cyc0.size() == 2) begin
      d1 = done_cyc0.pop_front();
      check("pend_first_done", 32'(d1 - t0), 32'd46);
      check("pend_gap", 32'(done_cyc0.pop_front() - d1), 32'd43);
    end
    verify0("pend_a", oh, om, os, 8'd1, 8'd2, 8'd3);
    verify0("pend_b", 5'd23, 6'd59, 6'd1, 8'd1, 8'd2, 8'd3);
    irq0 = 1'b0;
    repeat (100) @(posedge clock);
    check("pend_no_third", 32'(done_cyc0.size()), 32'd0);

    // Range error: hr=24 sets it, stays through a clean sequence, reset clears.
    core_val[2] = 8'h18;
    fire0(t0);
    wait_done0(1);
    void'(done_cyc0.pop_front());
    verify0("rng_bad", 5'd23, 6'd59, 6'd1, 8'd1, 8'd2, 8'h18);
    irq0 = 1'b0; repeat (3) @(posedge clock);
    core_val[2] = 8'd4;
    fire0(t0);
    wait_done0(1);
    void'(done_cyc0.pop_front());
    verify0("rng_clean", 5'd23, 6'd59, 6'd1, 8'd1, 8'd2, 8'd4);
    irq0 = 1'b0;
    @(negedge clock) reset_n = 1'b0;
    #1 check("rng_reset_clear", 32'(rerr0), 32'd0);
    exp_err = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    repeat (4) @(posedge clock);

    // Reset during W301 strobe: strobes and bus release at once, no done.
    fire0(t0);
    wait_trace(5);
    #2 reset_n = 1'b0;
    #1;
    check("mid_write_n", 32'(w0), 32'd1);
    check("mid_aen", 32'(aen0), 32'd1);
    check("mid_oe", 32'(oe0), 32'd0);
    check("mid_cur", 32'({ch0, cm0, cs0}), 32'd0);
    irq0 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    repeat (60) @(posedge clock);
    check("mid_no_done", 32'(done_cyc0.size()), 32'd0);
    trace0.delete(); width0.delete();
    fire0(t0);
    wait_done0(1);
    if (done_cyc0.size() > 0) check("post_done_time", 32'(done_cyc0.pop_front() - t0), 32'd46);
    verify0("post", 5'd23, 6'd59, 6'd1, 8'd1, 8'd2, 8'd4);
    irq0 = 1'b0;
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
